// File: rtl/pipe_stage_chain_if.sv
// Handshake, control and observation bundle for pipe_stage_chain.
interface pipe_stage_chain_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
);
  logic                     in_valid;
  logic [WIDTH-1:0]         in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_ready;
  logic                     stall;
  logic                     flush;
  logic [DEPTH-1:0]         flush_mask;
  logic [DEPTH-1:0]         stage_valid;
  logic [DEPTH*WIDTH-1:0]   stage_data;
  logic [CNT_W-1:0]         count;

  // Producer/consumer/control side
  modport master (
    output in_valid, in_data, out_ready, stall, flush, flush_mask,
    input  in_ready, out_valid, out_data, stage_valid, stage_data, count
  );

  // Pipeline side
  modport slave (
    input  in_valid, in_data, out_ready, stall, flush, flush_mask,
    output in_ready, out_valid, out_data, stage_valid, stage_data, count
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Elastic DEPTH-stage pipeline with bubble collapse, selective flush and occupancy count.
module pipe_stage_chain #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input logic           clk,
  input logic           rst_n,
  pipe_stage_chain_if.slave bus
);

  logic [DEPTH-1:0]            valid_q, valid_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_nxt;
  logic [CNT_W-1:0]            count_q, count_nxt;
  logic                        live_q;
  logic [DEPTH:0]              rdy;
  logic [DEPTH-1:0]            mv;
  logic                        go;
  logic                        in_ready_c;
  logic                        accept;

  // Ready ripple from the consumer back to the producer; an empty stage is always ready
  always_comb begin
    rdy        = '0;
    mv         = '0;
    rdy[DEPTH] = bus.out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      mv[k]  = valid_q[k] & rdy[k+1];
      rdy[k] = ~valid_q[k] | mv[k];
    end
  end

  // Movement is allowed only once out of reset and with neither stall nor flush
  assign go         = live_q & ~bus.stall & ~bus.flush;
  assign in_ready_c = go & rdy[0];
  assign accept     = bus.in_valid & in_ready_c;

  // Next-state valid/data: flush kills masked stages, otherwise stages advance
  always_comb begin
    valid_nxt = valid_q;
    data_nxt  = data_q;
    count_nxt = '0;
    if (bus.flush) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (bus.flush_mask[k]) begin
          valid_nxt[k] = 1'b0;
          data_nxt[k]  = '0;
        end
      end
    end else if (go) begin
      if (accept) begin
        valid_nxt[0] = 1'b1;
        data_nxt[0]  = bus.in_data;
      end else if (mv[0]) begin
        valid_nxt[0] = 1'b0;
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (mv[k-1]) begin
          valid_nxt[k] = 1'b1;
          data_nxt[k]  = data_q[k-1];
        end else if (mv[k]) begin
          valid_nxt[k] = 1'b0;
        end
      end
    end
    for (int k = 0; k < int'(DEPTH); k++) begin
      count_nxt = count_nxt + CNT_W'(valid_nxt[k]);
    end
  end

  // State registers; live_q keeps in_ready low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q  <= 1'b0;
      valid_q <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      live_q  <= 1'b1;
      valid_q <= valid_nxt;
      data_q  <= data_nxt;
      count_q <= count_nxt;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = go & valid_q[DEPTH-1];
  assign bus.out_data    = data_q[DEPTH-1];
  assign bus.stage_valid = valid_q;
  assign bus.stage_data  = data_q;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed scenarios plus randomized run against a slot model.
module tb_pipe_stage_chain;
  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam int unsigned CW = $clog2(D + 1);

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pipe_stage_chain_if #(.WIDTH(W), .DEPTH(D)) bus ();

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model: slot array advanced oldest-first
  bit         m_v[D];
  logic [7:0] m_d[D];

  task automatic model_clear();
    for (int k = 0; k < int'(D); k++) begin
      m_v[k] = 1'b0;
      m_d[k] = 8'h00;
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int k = 0; k < int'(D); k++) n += int'(m_v[k]);
    return n;
  endfunction

  task automatic model_edge();
    if (bus.flush) begin
      for (int k = 0; k < int'(D); k++) begin
        if (bus.flush_mask[k]) begin
          m_v[k] = 1'b0;
          m_d[k] = 8'h00;
        end
      end
    end else if (!bus.stall) begin
      if (m_v[D-1] && bus.out_ready) m_v[D-1] = 1'b0;
      for (int k = int'(D) - 2; k >= 0; k--) begin
        if (m_v[k] && !m_v[k+1]) begin
          m_d[k+1] = m_d[k];
          m_v[k+1] = 1'b1;
          m_v[k]   = 1'b0;
        end
      end
      if (bus.in_valid && !m_v[0]) begin
        m_d[0] = bus.in_data;
        m_v[0] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.flush_mask = '0;
  endtask

  task automatic push4(input logic [31:0] words);
    logic [31:0] w;
    w = words;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w[31-8*i -: 8];
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    total++;
    if (bus.stage_valid !== 4'b0000 || bus.stage_data !== 32'h0 || bus.count !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: valid=%b data=%h count=%0d required 0000/0/0",
               bus.stage_valid, bus.stage_data, bus.count);
    end
    total++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 0/0", bus.in_ready, bus.out_valid);
    end
    #2 rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_ready: in_ready=%b required 0 before first edge", bus.in_ready);
    end
    tick();
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_fill();
    logic [7:0] words[4];
    words[0] = 8'h44; words[1] = 8'h33; words[2] = 8'h22; words[3] = 8'h11;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = words[i];
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL fill_ready: push %0d in_ready=%b required 1", i, bus.in_ready);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.stage_data !== 32'h44332211 || bus.count !== 3'd4) begin
      bad++;
      $display("FAIL fill_contents: data=%h count=%0d required 44332211/4", bus.stage_data, bus.count);
    end
    total++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h44) begin
      bad++;
      $display("FAIL fill_ends: in_ready=%b out_valid=%b out_data=%h required 0/1/44",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_drain();
    logic [7:0] words[4];
    words[0] = 8'h44; words[1] = 8'h33; words[2] = 8'h22; words[3] = 8'h11;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== words[i] || bus.count !== CW'(4 - i)) begin
        bad++;
        $display("FAIL drain_word: beat %0d valid=%b data=%h count=%0d required 1/%h/%0d",
                 i, bus.out_valid, bus.out_data, bus.count, words[i], 4 - i);
      end
      tick();
    end
    total++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      bad++;
      $display("FAIL drain_empty: out_valid=%b count=%0d required 0/0", bus.out_valid, bus.count);
    end
  endtask

  task automatic test_bubble();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hAA;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hBB;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    total++;
    if (bus.stage_valid !== 4'b1100 || bus.count !== 3'd2 || bus.stage_data[31:16] !== 16'hAABB) begin
      bad++;
      $display("FAIL bubble_collapse: valid=%b count=%0d data=%h required 1100/2/AABBxxxx",
               bus.stage_valid, bus.count, bus.stage_data);
    end
    bus.out_ready = 1'b1;
    tick(); tick();
    total++;
    if (bus.count !== 3'd0) begin
      bad++;
      $display("FAIL bubble_drain: count=%0d required 0", bus.count);
    end
  endtask

  task automatic test_flush();
    logic [7:0] got[$];
    push4(32'h44332211);
    bus.in_valid   = 1'b1;
    bus.in_data    = 8'hFF;
    bus.flush      = 1'b1;
    bus.flush_mask = 4'b0011;
    #1;
    total++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_handshake: in_ready=%b out_valid=%b required 0/0", bus.in_ready, bus.out_valid);
    end
    tick();
    bus.flush      = 1'b0;
    bus.flush_mask = '0;
    bus.in_valid   = 1'b0;
    #1;
    total++;
    if (bus.stage_valid !== 4'b1100 || bus.stage_data !== 32'h44330000 || bus.count !== 3'd2) begin
      bad++;
      $display("FAIL flush_state: valid=%b data=%h count=%0d required 1100/44330000/2",
               bus.stage_valid, bus.stage_data, bus.count);
    end
    bus.out_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) got.push_back(bus.out_data);
      tick();
    end
    total++;
    if (got.size() != 2 || got[0] !== 8'h44 || got[1] !== 8'h33) begin
      bad++;
      $display("FAIL flush_drain: words=%0d required 2 words 44,33", got.size());
    end
  endtask

  task automatic test_stall();
    logic [7:0] got[$];
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hCC;
    tick();
    bus.in_data = 8'hDD;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    bus.stall    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL stall_handshake: cycle %0d in_ready=%b out_valid=%b required 0/0",
                 i, bus.in_ready, bus.out_valid);
      end
      tick();
      total++;
      if (bus.stage_valid !== 4'b1100 || bus.stage_data[31:16] !== 16'hCCDD) begin
        bad++;
        $display("FAIL stall_frozen: cycle %0d valid=%b data=%h required 1100/CCDDxxxx",
                 i, bus.stage_valid, bus.stage_data);
      end
    end
    bus.stall    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) got.push_back(bus.out_data);
      tick();
    end
    total++;
    if (got.size() != 2 || got[0] !== 8'hCC || got[1] !== 8'hDD) begin
      bad++;
      $display("FAIL stall_resume: words=%0d required 2 words CC,DD", got.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] w;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = 8'($urandom);
      q.push_back(w);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      w = 8'($urandom);
      bus.in_data   = w;
      bus.out_ready = 1'b1;
      #1;
      total++;
      if (bus.count !== 3'd4 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== q[0]) begin
        bad++;
        $display("FAIL push_pop_full: beat %0d count=%0d in_ready=%b out_valid=%b data=%h required 4/1/1/%h",
                 i, bus.count, bus.in_ready, bus.out_valid, bus.out_data, q[0]);
      end
      void'(q.pop_front());
      q.push_back(w);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.stage_valid !== 4'b0000 || bus.stage_data !== 32'h0 || bus.count !== 3'd0 ||
        bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      bad++;
      $display("FAIL async_reset: valid=%b data=%h count=%0d in_ready=%b out_valid=%b required all 0",
               bus.stage_valid, bus.stage_data, bus.count, bus.in_ready, bus.out_valid);
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] exp_sd;
    logic [3:0]  exp_sv;
    bit          exp_ir;
    bit          exp_ov;
    int          errs = 0;
    model_clear();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.in_valid   = ($urandom_range(0, 9) < 6);
      bus.in_data    = 8'($urandom);
      bus.out_ready  = ($urandom_range(0, 1) == 1);
      bus.stall      = ($urandom_range(0, 9) == 0);
      bus.flush      = ($urandom_range(0, 19) == 0);
      bus.flush_mask = 4'($urandom_range(0, 15));
      #1;
      for (int k = 0; k < int'(D); k++) begin
        exp_sd[k*8 +: 8] = m_d[k];
        exp_sv[k]        = m_v[k];
      end
      exp_ir = !bus.stall && !bus.flush && (model_count() < int'(D) || bus.out_ready);
      exp_ov = !bus.stall && !bus.flush && m_v[D-1];
      total++;
      if (bus.stage_valid !== exp_sv || bus.stage_data !== exp_sd || bus.count !== CW'(model_count()) ||
          bus.in_ready !== exp_ir || bus.out_valid !== exp_ov || (exp_ov && bus.out_data !== m_d[D-1])) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle: cyc %0d valid=%b data=%h count=%0d ir=%b ov=%b required %b/%h/%0d/%b/%b",
                   cyc, bus.stage_valid, bus.stage_data, bus.count, bus.in_ready, bus.out_valid,
                   exp_sv, exp_sd, model_count(), exp_ir, exp_ov);
      end
      model_edge();
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_fill();
    test_drain();
    test_bubble();
    test_flush();
    test_stall();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
